// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller slice.
// Holds the memory-bus widths, the controller FSM encoding and two helpers:
//   addr_err    - flags a misaligned or out-of-range byte address
//   merge_bytes - applies a byte write-enable mask to a stored word
package dmem_ctrl_pkg;

  localparam int MemWidth     = 32;
  localparam int MemUnit      = 4;
  localparam int MemAddrWidth = 32;
  localparam int WaitCntWidth = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // An address is bad when it is not word aligned or its word number lies
  // beyond the array. The comparison is done on the full word number, so
  // high address bits cannot alias into a valid index.
  function automatic logic addr_err(input logic [MemAddrWidth-1:0] addr,
                                    input logic [MemAddrWidth-1:0] depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[MemAddrWidth-1:2]} >= depth);
  endfunction

  function automatic logic [MemWidth-1:0] merge_bytes(input logic [MemWidth-1:0] old_word,
                                                      input logic [MemWidth-1:0] new_word,
                                                      input logic [MemUnit-1:0]  wem);
    logic [MemWidth-1:0] result;
    result = old_word;
    for (int b = 0; b < MemUnit; b++) begin
      if (wem[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/dmem_ctrl_ram.sv
// Word-organised data array for dmem_ctrl.
// Ports:
//   clk      - write clock
//   we_i     - write strobe for this edge
//   wem_i    - byte enables for the write
//   widx_i   - word index being written
//   wdata_i  - write data
//   ridx_i   - word index being read (combinational read)
//   rdata_o  - read data
// Contents are never reset.
module dmem_ram
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int IdxWidth = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [MemUnit-1:0]  wem_i,
  input  logic [IdxWidth-1:0] widx_i,
  input  logic [MemWidth-1:0] wdata_i,
  input  logic [IdxWidth-1:0] ridx_i,
  output logic [MemWidth-1:0] rdata_o
);

  logic [MemWidth-1:0] mem_q [DEPTH];

  // Byte-masked write: unmasked bytes keep their previous contents.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i] <= merge_bytes(mem_q[widx_i], wdata_i, wem_i);
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder with a configurable number of wait cycles.
// A request is captured when cs_i meets mem_ready_o, the FSM waits
// WAIT_CYCLES cycles and then gives a one-cycle response pulse.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   cs_i          - request strobe
//   mem_we_i      - 1 = write, 0 = read
//   mem_wem_i     - byte write enables
//   mem_din_i     - write data
//   mem_addr_i    - byte address
//   mem_ready_o   - a request can be accepted this cycle
//   mem_rvalid_o  - one-cycle response pulse
//   mem_dout_o    - read data, zero outside a read response
//   mem_err_o     - response error flag
//   stall_o       - upstream hold request
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs_i,
  input  logic                    mem_we_i,
  input  logic [MemUnit-1:0]      mem_wem_i,
  input  logic [MemWidth-1:0]     mem_din_i,
  input  logic [MemAddrWidth-1:0] mem_addr_i,
  output logic                    mem_ready_o,
  output logic                    mem_rvalid_o,
  output logic [MemWidth-1:0]     mem_dout_o,
  output logic                    mem_err_o,
  output logic                    stall_o
);

  localparam int IdxWidth = $clog2(DEPTH);
  localparam logic [MemAddrWidth-1:0] DepthW = MemAddrWidth'(DEPTH);
  localparam logic [WaitCntWidth-1:0] WaitLoad =
    (WAIT_CYCLES > 0) ? WaitCntWidth'(WAIT_CYCLES - 1) : '0;

  dmem_state_e             state_q, state_d;
  logic [WaitCntWidth-1:0] cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [MemUnit-1:0]      wem_q, wem_d;
  logic [MemWidth-1:0]     din_q, din_d;
  logic [MemAddrWidth-1:0] addr_q, addr_d;

  logic                    accept;
  logic                    in_resp;
  logic                    resp_err;
  logic                    ram_we;
  logic [MemWidth-1:0]     ram_rdata;

  assign mem_ready_o = (state_q != ST_WAIT);
  assign accept      = cs_i && mem_ready_o;
  assign stall_o     = cs_i && !mem_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wem_d   = wem_q;
    din_d   = din_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          we_d   = mem_we_i;
          wem_d  = mem_wem_i;
          din_d  = mem_din_i;
          addr_d = mem_addr_i;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WaitLoad;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wem_q   <= '0;
      din_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wem_q   <= wem_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
    end
  end

  // The array is written on the edge that enters RESP. The *_d values are
  // the request being entered: fresh inputs when RESP follows an accept
  // directly (zero wait), otherwise the captured registers. Because the
  // write happens at entry, a reset during WAIT leaves the array untouched.
  assign ram_we = (state_d == ST_RESP) && we_d && !addr_err(addr_d, DepthW);

  dmem_ram #(
    .DEPTH    (DEPTH),
    .IdxWidth (IdxWidth)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .wem_i   (wem_d),
    .widx_i  (addr_d[IdxWidth+1:2]),
    .wdata_i (din_d),
    .ridx_i  (addr_q[IdxWidth+1:2]),
    .rdata_o (ram_rdata)
  );

  assign in_resp      = (state_q == ST_RESP);
  assign resp_err     = addr_err(addr_q, DepthW);
  assign mem_rvalid_o = in_resp;
  assign mem_err_o    = in_resp && resp_err;
  assign mem_dout_o   = (in_resp && !we_q && !resp_err) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl.
// Main instance uses WAIT_CYCLES=1; a second instance with WAIT_CYCLES=0
// covers the single-cycle throughput case.
module tb_dmem_ctrl;

  localparam int WAIT  = 1;
  localparam int DEPTH = 1024;

  typedef struct {
    logic        we;
    logic [3:0]  wem;
    logic [31:0] din;
    logic [31:0] addr;
    int          edge_n;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] dout;
  } resp_t;

  logic        clk;
  logic        rst;
  logic        cs, we;
  logic [3:0]  wem;
  logic [31:0] din, addr;
  logic        ready, rvalid, err, stall;
  logic [31:0] dout;

  logic        cs0, we0;
  logic [3:0]  wem0;
  logic [31:0] din0, addr0;
  logic        ready0, rvalid0, err0, stall0;
  logic [31:0] dout0;

  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          busy = 0;
  int          acc_cyc = -1;
  int          last_resp_cyc = -1;
  int          prev_resp_cyc = -1;
  logic [31:0] last_rdata = 32'h0;

  req_t        sbq[$];
  resp_t       sbq0[$];
  logic [31:0] mmem [int];

  dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .cs_i         (cs),
    .mem_we_i     (we),
    .mem_wem_i    (wem),
    .mem_din_i    (din),
    .mem_addr_i   (addr),
    .mem_ready_o  (ready),
    .mem_rvalid_o (rvalid),
    .mem_dout_o   (dout),
    .mem_err_o    (err),
    .stall_o      (stall)
  );

  dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .cs_i         (cs0),
    .mem_we_i     (we0),
    .mem_wem_i    (wem0),
    .mem_din_i    (din0),
    .mem_addr_i   (addr0),
    .mem_ready_o  (ready0),
    .mem_rvalid_o (rvalid0),
    .mem_dout_o   (dout0),
    .mem_err_o    (err0),
    .stall_o      (stall0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference acceptance model: after an accept the responder is busy for
  // WAIT cycles; requests are queued with the edge their response is due.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        busy = 0;
        sbq.delete();
      end else begin
        req_t r;
        cyc = cyc + 1;
        if (cs && busy == 0) begin
          r.we     = we;
          r.wem    = wem;
          r.din    = din;
          r.addr   = addr;
          r.edge_n = cyc + WAIT;
          sbq.push_back(r);
          acc_cyc = cyc;
          busy    = WAIT;
        end else if (busy > 0) begin
          busy = busy - 1;
        end
      end
    end
  end

  // Response monitor: compares every response with the model memory and
  // checks handshake outputs every cycle.
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (ready !== (busy == 0)) $display("[TB] FAIL ready: got %b want %b at cyc %0d", ready, (busy == 0), cyc);
      else passed++;
      checks++;
      if (stall !== (cs && busy != 0)) $display("[TB] FAIL stall: got %b want %b at cyc %0d", stall, (cs && busy != 0), cyc);
      else passed++;
      if (rvalid === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          $display("[TB] FAIL unexpected_rvalid: got 1 want 0 at cyc %0d", cyc);
        end else begin
          req_t        r;
          logic        e_err;
          logic [31:0] e_dout;
          int          idx;
          passed++;
          r      = sbq.pop_front();
          e_err  = (r.addr[1:0] != 2'b00) || (r.addr[31:2] >= 30'(DEPTH));
          idx    = int'(r.addr[11:2]);
          e_dout = 32'h0;
          if (!e_err && !r.we) e_dout = mmem.exists(idx) ? mmem[idx] : 32'h0;
          checks++;
          if (r.edge_n !== cyc) $display("[TB] FAIL latency: got cyc %0d want cyc %0d", cyc, r.edge_n);
          else passed++;
          checks++;
          if (err !== e_err) $display("[TB] FAIL resp_err addr %h: got %b want %b", r.addr, err, e_err);
          else passed++;
          checks++;
          if (dout !== e_dout) $display("[TB] FAIL resp_dout addr %h: got %h want %h", r.addr, dout, e_dout);
          else passed++;
          if (!e_err && r.we) begin
            logic [31:0] w;
            w = mmem.exists(idx) ? mmem[idx] : 32'h0;
            for (int b = 0; b < 4; b++) if (r.wem[b]) w[8*b +: 8] = r.din[8*b +: 8];
            mmem[idx] = w;
          end
          if (!r.we) last_rdata = dout;
          prev_resp_cyc = last_resp_cyc;
          last_resp_cyc = cyc;
        end
      end else begin
        checks++;
        if (err !== 1'b0 || dout !== 32'h0) $display("[TB] FAIL idle_outputs: got err %b dout %h want 0/0", err, dout);
        else passed++;
        if (sbq.size() > 0 && sbq[0].edge_n < cyc) begin
          checks++;
          $display("[TB] FAIL missing_rvalid: got 0 want 1 at cyc %0d", cyc);
          void'(sbq.pop_front());
        end
      end
    end
  end

  // Present a request and hold it until the model sees it accepted.
  task automatic issue(input logic w, input logic [3:0] m, input logic [31:0] d, input logic [31:0] a);
    int n;
    cs = 1'b1; we = w; wem = m; din = d; addr = a;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (acc_cyc != cyc && n < 20);
    if (acc_cyc != cyc) begin
      checks++;
      $display("[TB] FAIL accept_timeout addr %h: got no accept want accept", a);
    end
  endtask

  task automatic drain();
    int n;
    cs = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sbq.size() != 0) $display("[TB] FAIL drain_timeout: got %0d pending want 0", sbq.size());
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; we = 1'b0; wem = 4'h0; din = 32'h0; addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1)  $display("[TB] FAIL rst_ready: got %b want 1", ready);   else passed++;
    checks++; if (rvalid !== 1'b0) $display("[TB] FAIL rst_rvalid: got %b want 0", rvalid); else passed++;
    checks++; if (dout !== 32'h0)  $display("[TB] FAIL rst_dout: got %h want 0", dout);     else passed++;
    checks++; if (err !== 1'b0)    $display("[TB] FAIL rst_err: got %b want 0", err);       else passed++;
    checks++; if (stall !== 1'b0)  $display("[TB] FAIL rst_stall: got %b want 0", stall);   else passed++;
    cs = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    issue(1'b1, 4'hF, 32'hDEADBEEF, 32'h10);
    issue(1'b0, 4'h0, 32'h0, 32'h10);
    drain();
    checks++;
    if (last_rdata !== 32'hDEADBEEF) $display("[TB] FAIL wr_rd_data: got %h want DEADBEEF", last_rdata);
    else passed++;
  endtask

  task automatic test_byte_mask();
    issue(1'b1, 4'hF, 32'h11223344, 32'h20);
    drain();
    issue(1'b1, 4'h5, 32'hAABBCCDD, 32'h20);
    drain();
    issue(1'b0, 4'h0, 32'h0, 32'h20);
    drain();
    checks++;
    if (last_rdata !== 32'h11BB33DD) $display("[TB] FAIL byte_mask: got %h want 11BB33DD", last_rdata);
    else passed++;
    issue(1'b1, 4'h0, 32'hFFFFFFFF, 32'h20);
    issue(1'b0, 4'h0, 32'h0, 32'h20);
    drain();
    checks++;
    if (last_rdata !== 32'h11BB33DD) $display("[TB] FAIL wem_zero: got %h want 11BB33DD", last_rdata);
    else passed++;
  endtask

  task automatic test_errors();
    issue(1'b1, 4'hF, 32'h12345678, 32'h40);
    issue(1'b0, 4'h0, 32'h0, 32'h22);
    issue(1'b0, 4'h0, 32'h0, 32'h1000);
    issue(1'b1, 4'hF, 32'hBAD0BAD0, 32'h1040);
    issue(1'b1, 4'hF, 32'hBAD1BAD1, 32'h42);
    issue(1'b0, 4'h0, 32'h0, 32'h40);
    drain();
    checks++;
    if (last_rdata !== 32'h12345678) $display("[TB] FAIL err_no_write: got %h want 12345678", last_rdata);
    else passed++;
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 4'hF, 32'hCAFEF00D, 32'h50);
    issue(1'b0, 4'h0, 32'h0, 32'h50);
    drain();
    checks++;
    if (last_resp_cyc - prev_resp_cyc != WAIT + 1)
      $display("[TB] FAIL b2b_spacing: got %0d want %0d", last_resp_cyc - prev_resp_cyc, WAIT + 1);
    else passed++;
    checks++;
    if (last_rdata !== 32'hCAFEF00D) $display("[TB] FAIL b2b_data: got %h want CAFEF00D", last_rdata);
    else passed++;
  endtask

  task automatic test_reset_in_wait();
    issue(1'b1, 4'hF, 32'h00000000, 32'h30);
    drain();
    issue(1'b1, 4'hF, 32'h55AA55AA, 32'h30);
    cs = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b1)  $display("[TB] FAIL rstw_ready: got %b want 1", ready);   else passed++;
    checks++; if (rvalid !== 1'b0) $display("[TB] FAIL rstw_rvalid: got %b want 0", rvalid); else passed++;
    checks++; if (dout !== 32'h0)  $display("[TB] FAIL rstw_dout: got %h want 0", dout);     else passed++;
    checks++; if (err !== 1'b0)    $display("[TB] FAIL rstw_err: got %b want 0", err);       else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    issue(1'b0, 4'h0, 32'h0, 32'h30);
    drain();
    checks++;
    if (last_rdata !== 32'h00000000) $display("[TB] FAIL rstw_aborted: got %h want 00000000", last_rdata);
    else passed++;
  endtask

  task automatic test_zero_wait();
    resp_t e;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        cs0 = 1'b1; we0 = 1'b1; wem0 = 4'hF; din0 = 32'h10000000 + i; addr0 = 32'(4 * i);
        e.err = 1'b0; e.dout = 32'h0;
      end else begin
        cs0 = 1'b1; we0 = 1'b0; wem0 = 4'h0; din0 = 32'h0; addr0 = 32'(4 * (7 - i));
        e.err = 1'b0; e.dout = 32'h10000000 + (7 - i);
      end
      sbq0.push_back(e);
      checks++;
      if (stall0 !== 1'b0) $display("[TB] FAIL zw_stall %0d: got %b want 0", i, stall0);
      else passed++;
      @(posedge clk); #1;
      e = sbq0.pop_front();
      checks++;
      if (rvalid0 !== 1'b1) $display("[TB] FAIL zw_rvalid %0d: got %b want 1", i, rvalid0);
      else passed++;
      checks++;
      if (err0 !== e.err || dout0 !== e.dout)
        $display("[TB] FAIL zw_resp %0d: got %b/%h want %b/%h", i, err0, dout0, e.err, e.dout);
      else passed++;
    end
    cs0 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rvalid0 !== 1'b0) $display("[TB] FAIL zw_idle: got %b want 0", rvalid0);
    else passed++;
  endtask

  initial begin
    cs0 = 1'b0; we0 = 1'b0; wem0 = 4'h0; din0 = 32'h0; addr0 = 32'h0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_errors();
    test_back_to_back();
    test_reset_in_wait();
    test_zero_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words in the data array (power of two).
REQ-002 Parameter WAIT_CYCLES, default 1, extra cycles between request accept and response (0..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cs_i  input  1  request strobe from the EX/MEM pipeline register.
REQ-006 mem_we_i  input  1  1 = write, 0 = read.
REQ-007 mem_wem_i  input  `MemUnit (4)  byte write enables; bit n enables byte n (bits 8n+7:8n).
REQ-008 mem_din_i  input  `MemWidth (32)  write data.
REQ-009 mem_addr_i  input  `MemAddrWidth (32)  byte address.
REQ-010 mem_ready_o  output  1  responder can accept a request this cycle.
REQ-011 mem_rvalid_o  output  1  one-cycle response pulse, for reads and writes.
REQ-012 mem_dout_o  output  `MemWidth  read data, valid only while mem_rvalid_o=1.
REQ-013 mem_err_o  output  1  response carries an error, valid only with mem_rvalid_o.
REQ-014 stall_o  output  1  cs_i && !mem_ready_o; pipeline hold request (drops lden upstream).

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 mem_ready_o SHALL be 1 in IDLE and RESP, 0 in WAIT.
REQ-017 A request is accepted on any edge where cs_i=1 and mem_ready_o=1; we, wem, din, addr are captured into internal registers.
REQ-018 On accept: WAIT_CYCLES>0 -> WAIT with counter loaded to WAIT_CYCLES-1; WAIT_CYCLES=0 -> RESP.
REQ-019 In WAIT: counter decrements each cycle; at counter 0, next state RESP; inputs ignored.
REQ-020 In RESP: mem_rvalid_o=1 for exactly that cycle; next state per REQ-018 if a new request is accepted, else IDLE.
REQ-021 Latency: accept at edge T -> mem_rvalid_o high in cycle T+1+WAIT_CYCLES; back-to-back throughput one request per WAIT_CYCLES+1 cycles.
REQ-022 Word index = captured addr[log2(DEPTH)+1:2].
REQ-023 Error when captured addr[1:0] != 0 or addr[31:2] >= DEPTH; then mem_err_o=1, mem_dout_o=0, no array write.
REQ-024 Write: on the edge entering RESP, array word updated only in bytes whose wem bit is 1; wem=0000 is a legal no-op write with normal ack.
REQ-025 Read: mem_dout_o = array word at index, reflecting all writes completed before this request's RESP cycle.
REQ-026 Write response: mem_dout_o=0, mem_err_o=0 unless REQ-023.
REQ-027 Outside RESP: mem_rvalid_o=0, mem_err_o=0, mem_dout_o=0.
REQ-028 cs_i deasserting while WAIT does not cancel the captured request.

Reset
REQ-029 rst=1 forces immediately: state IDLE, counter 0, captured registers 0, mem_rvalid_o=0, mem_err_o=0, mem_dout_o=0, mem_ready_o=1.
REQ-030 Reset during WAIT aborts the request: no array write, no response after release.
REQ-031 Array contents are not reset.

Structure
REQ-032 `MemWidth, `MemUnit, `MemAddrWidth come from the shared defines.v; FSM encodings are local constants.
REQ-033 The array SHALL be a sub-module dmem_ram (one port, synchronous byte-masked write, combinational read of the captured index).

Verification (WAIT_CYCLES=1, DEPTH=1024)
REQ-034 Write addr 0x10, din 0xDEADBEEF, wem 1111, then read 0x10 -> rvalid 2 cycles after each accept, read dout 0xDEADBEEF, err 0.
REQ-035 Preload 0x11223344 at 0x20; write wem 0101 din 0xAABBCCDD; read -> 0x11BB33DD.
REQ-036 Read addr 0x22 and addr 0x1000 -> err 1, dout 0; array unchanged.
REQ-037 Two requests held on cs_i continuously -> stall_o 1 during WAIT, second accept in first's RESP cycle, rvalid pulses 2 cycles apart.
REQ-038 Assert rst in WAIT of a write to 0x30 (old 0x0) -> outputs 0 at once, ready 1, later read of 0x30 returns 0x00000000.
REQ-039 Rebuild WAIT_CYCLES=0: read accepted at T -> rvalid at T+1; one request per cycle with stall_o 0.
